// File: rtl/spi_target_io.sv
// SPI target (mode 0, MSB first) with a small CPU register window.
// All SPI pins are oversampled in the clk domain; no second clock exists.
module spi_target_io #(
    parameter logic [7:0] FILL_BYTE = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] AD,
    input  logic [7:0] DI,
    output logic [7:0] DO,
    input  logic       rw,
    input  logic       cs,
    output logic       irq,
    input  logic       sck,
    input  logic       mosi,
    input  logic       ss_n,
    output logic       miso,
    output logic       miso_oe
);

    // Synchroniser chains; index 0 is the first flop, index 2 the edge-detect stage.
    logic [2:0] sck_sync;
    logic [2:0] ss_sync;
    logic [1:0] mosi_sync;

    // Gate for ss_n falls: only accepted once ss_n has been seen high after reset.
    logic [1:0] fill_cnt;
    logic       armed;

    // Register-window and shifter state.
    logic       rdy;
    logic       txe;
    logic       ovr;
    logic       ssact;
    logic       ie;
    logic [2:0] bit_cnt;
    logic [7:0] shift_rx;
    logic [7:0] shift_tx;
    logic [7:0] rx_data;
    logic [7:0] tx_hold;

    logic       sck_rise;
    logic       sck_fall;
    logic       ss_fall;
    logic       ss_rise;
    logic       cpu_rd;
    logic       cpu_wr;
    logic [7:0] tx_load;
    logic [7:0] rx_word;
    logic [7:0] rd_data;

    assign sck_rise = sck_sync[1] & ~sck_sync[2];
    assign sck_fall = ~sck_sync[1] & sck_sync[2];
    assign ss_fall  = armed & ~ss_sync[1] & ss_sync[2];
    assign ss_rise  = ss_sync[1] & ~ss_sync[2];
    assign cpu_rd   = cs & rw;
    assign cpu_wr   = cs & ~rw;
    assign tx_load  = txe ? FILL_BYTE : tx_hold;
    assign rx_word  = {shift_rx[6:0], mosi_sync[1]};
    assign miso     = shift_tx[7];
    assign miso_oe  = ssact;

    // Bring the asynchronous SPI pins into the clk domain.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            sck_sync  <= 3'b000;
            ss_sync   <= 3'b111;
            mosi_sync <= 2'b11;
        end else begin
            sck_sync  <= {sck_sync[1:0], sck};
            ss_sync   <= {ss_sync[1:0], ss_n};
            mosi_sync <= {mosi_sync[0], mosi};
        end
    end

    // Arm ss_n fall detection only after the chain holds real samples showing ss_n high,
    // so a select that was already low across reset is ignored.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fill_cnt <= 2'd0;
            armed    <= 1'b0;
        end else begin
            if (fill_cnt != 2'd3)
                fill_cnt <= fill_cnt + 2'd1;
            if (fill_cnt == 2'd3 && ss_sync[2])
                armed <= 1'b1;
        end
    end

    // CPU read multiplexer.
    always_comb begin
        // NOTE: default assignment first so no path leaves rd_data unassigned (no latch).
        rd_data = 8'h00;
        case (AD)
            3'd0:    rd_data = {rdy, txe, ovr, ssact, 3'b000, ie};
            3'd1:    rd_data = rx_data;
            default: rd_data = 8'h00;
        endcase
    end

    // CPU accesses, SPI shifting and status flags, with simultaneous-event priority.
    always_ff @(posedge clk) begin
        if (!rst) begin
            DO       <= 8'h00;
            irq      <= 1'b0;
            rdy      <= 1'b0;
            txe      <= 1'b1;
            ovr      <= 1'b0;
            ssact    <= 1'b0;
            ie       <= 1'b0;
            bit_cnt  <= 3'd0;
            shift_rx <= 8'h00;
            shift_tx <= FILL_BYTE;
            rx_data  <= 8'hFF;
            tx_hold  <= 8'hFF;
        end else begin
            // NOTE: when several statements below assign one flag, the last one in program
            // order wins; the ordering is what encodes simultaneous-event priority.
            if (cpu_rd) begin
                DO <= rd_data;
                if (AD == 3'd1)
                    rdy <= 1'b0;
            end
            if (cpu_wr && AD == 3'd0) begin
                ie <= DI[0];
                if (DI[5])
                    ovr <= 1'b0;
            end

            if (ss_fall) begin
                bit_cnt  <= 3'd0;
                shift_tx <= tx_load;
                txe      <= 1'b1;
                ssact    <= 1'b1;
            end else if (ss_rise) begin
                ssact   <= 1'b0;
                bit_cnt <= 3'd0;
            end else if (ssact) begin
                if (sck_rise) begin
                    shift_rx <= rx_word;
                    bit_cnt  <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        rx_data <= rx_word;
                        rdy     <= 1'b1;
                        if (rdy)
                            ovr <= 1'b1;
                    end
                end else if (sck_fall) begin
                    if (bit_cnt == 3'd0) begin
                        shift_tx <= tx_load;
                        txe      <= 1'b1;
                    end else begin
                        shift_tx <= {shift_tx[6:0], 1'b1};
                    end
                end
            end

            // A CPU write of the holding register overrides a same-edge consume.
            if (cpu_wr && AD == 3'd1) begin
                tx_hold <= DI;
                txe     <= 1'b0;
            end

            irq <= ie & rdy;
        end
    end

endmodule
